temporizador_prog: RTL and testbench

// - Programmable, prescaled interval timer: the parametrised successor of the fixed 1 s one-shot timer.
// - Period is loaded at start. One-shot or periodic mode is selected at start.
// - Supports abort and optional retrigger. A running count is exposed.
// - Sits between the ultrasonic/motion FSMs and the 50 MHz clock domain, generating trigger widths, echo timeouts and control ticks.

---
 rtl/temporizador_prog_pkg.sv | 12 +
 rtl/temporizador_prog_tick_gen.sv | 30 +++
 rtl/temporizador_prog.sv | 86 ++++++++
 tb/tb_temporizador_prog.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_prog_pkg.sv
// Shared definitions for the programmable interval timer.
// Callers use CLK_HZ to convert seconds into tick periods.
package temporizador_prog_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/temporizador_prog_tick_gen.sv
// Prescaler: one tick every PRESC enabled clocks.
// With PRESC==1 the counter stays at 0 and tick follows en.
module temporizador_prog_tick_gen #(
  parameter int PRESC = 1,
  parameter int PW    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc;

  assign tick = en && (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/temporizador_prog.sv
// Programmable prescaled interval timer, one-shot or auto-reload.
// Priority each clock: stop, then start, then tick.
module temporizador_prog
  import temporizador_prog_pkg::*;
#(
  parameter int W      = 26,
  parameter int PRESC  = 1,
  parameter int RETRIG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         stop,
  input  logic         periodic,
  input  logic [W-1:0] period,
  output logic         out,
  output logic         done,
  output logic [W-1:0] count
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam bit RT = (RETRIG != 0);

  state_t       state;
  logic [W-1:0] period_q;
  logic         periodic_q;
  logic         tick;
  logic         start;

  assign start = init && !stop
              && ((state == ST_IDLE) || RT);

  temporizador_prog_tick_gen #(
    .PRESC(PRESC),
    .PW   (PW)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (stop || start),
    .en  (state == ST_COUNT),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out        <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        out   <= 1'b0;
        count <= '0;
      end else if (start) begin
        count <= '0;
        if (period != '0) begin
          period_q   <= period;
          periodic_q <= periodic;
          state      <= ST_COUNT;
          out        <= 1'b1;
        end else begin
          done  <= 1'b1;
          state <= ST_IDLE;
          out   <= 1'b0;
        end
      end else if (tick) begin
        // terminal compare first, so count never wraps
        if (count == period_q - 1'b1) begin
          done  <= 1'b1;
          count <= '0;
          if (!periodic_q) begin
            state <= ST_IDLE;
            out   <= 1'b0;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_temporizador_prog.sv
// Bench for temporizador_prog: three builds share one stimulus bus.
// d1: PRESC=1 RETRIG=0, d4: PRESC=4 RETRIG=0, dr: PRESC=1 RETRIG=1.
module tb_temporizador_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         stop;
  logic         periodic;
  logic [W-1:0] period;

  logic         out1, done1;
  logic         out4, done4;
  logic         outr, doner;
  logic [W-1:0] cnt1, cnt4, cntr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic o;
    logic d;
    int   c;
  } exp_t;

  typedef struct {
    logic i;
    logic s;
    int   p;
    logic m;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  temporizador_prog #(.W(W), .PRESC(1), .RETRIG(0)) d1 (
    .clk(clk), .rst(rst), .init(init), .stop(stop),
    .periodic(periodic), .period(period),
    .out(out1), .done(done1), .count(cnt1)
  );

  temporizador_prog #(.W(W), .PRESC(4), .RETRIG(0)) d4 (
    .clk(clk), .rst(rst), .init(init), .stop(stop),
    .periodic(periodic), .period(period),
    .out(out4), .done(done4), .count(cnt4)
  );

  temporizador_prog #(.W(W), .PRESC(1), .RETRIG(1)) dr (
    .clk(clk), .rst(rst), .init(init), .stop(stop),
    .periodic(periodic), .period(period),
    .out(outr), .done(doner), .count(cntr)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk3(string tag, logic o, logic d,
                      logic [W-1:0] c, exp_t e);
    chk({tag, ".out"}, int'(o), int'(e.o));
    chk({tag, ".done"}, int'(d), int'(e.d));
    chk({tag, ".count"}, int'(c), e.c);
  endtask

  task automatic drive(logic i, logic s, int p, logic m);
    @(negedge clk);
    init     = i;
    stop     = s;
    period   = p[W-1:0];
    periodic = m;
  endtask

  task automatic step(logic i, logic s, int p, logic m);
    drive(i, s, p, m);
    @(posedge clk);
    #1;
  endtask

  // one-shot reference: start sampled at edge s, period n
  function automatic exp_t oneshot(int k, int s, int n);
    exp_t e;
    int   j;
    j = k - s;
    e = '{o: 1'b0, d: 1'b0, c: 0};
    if (j >= 0 && j < n) e = '{o: 1'b1, d: 1'b0, c: j};
    else if (j == n)     e = '{o: 1'b0, d: 1'b1, c: 0};
    return e;
  endfunction

  function automatic void add(logic i, logic s, int p, logic m,
                              logic o, logic d, int c);
    vec_t v;
    v.i = i; v.s = s; v.p = p; v.m = m;
    v.e = '{o: o, d: d, c: c};
    tbl.push_back(v);
  endfunction

  task automatic retrig_run(int r, int p);
    exp_t e;
    step(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      step((k == 0) || (k == r), 1'b0, (k == 0) ? 10 : p, 1'b0);
      e = (k < r) ? oneshot(k, 0, 10) : oneshot(k, r, p);
      chk3($sformatf("retrig r%0d p%0d k%0d dr", r, p, k),
           outr, doner, cntr, e);
      chk3($sformatf("retrig r%0d p%0d k%0d d1", r, p, k),
           out1, done1, cnt1, oneshot(k, 0, 10));
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; init = 1'b0; stop = 1'b0;
    periodic = 1'b0; period = '0;

    add(1, 0, 5, 0, 1, 0, 0);
    add(0, 0, 5, 0, 1, 0, 1);
    add(0, 0, 5, 0, 1, 0, 2);
    add(1, 0, 3, 0, 1, 0, 3);
    add(0, 0, 5, 0, 1, 0, 4);
    add(0, 0, 5, 0, 0, 1, 0);
    add(0, 0, 5, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0, 0);
    add(0, 0, 5, 0, 0, 0, 0);
    add(1, 0, 2, 0, 1, 0, 0);
    add(0, 0, 2, 0, 1, 0, 1);
    add(0, 1, 2, 0, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0);

    #12;
    chk3("reset d1", out1, done1, cnt1, '{o: 0, d: 0, c: 0});
    chk3("reset d4", out4, done4, cnt4, '{o: 0, d: 0, c: 0});
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      drive(tbl[n].i, tbl[n].s, tbl[n].p, tbl[n].m);
      sb.push_back(tbl[n].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk3($sformatf("vec%0d", n), out1, done1, cnt1, e);
    end

    // periodic, PRESC=4, period=3
    step(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k <= 36; k++) begin
      step(k == 0, 1'b0, 3, 1'b1);
      chk($sformatf("per k%0d out", k), int'(out4), 1);
      chk($sformatf("per k%0d done", k), int'(done4),
          int'(k > 0 && (k % 12) == 0));
      chk($sformatf("per k%0d count", k), int'(cnt4), (k / 4) % 3);
    end
    step(1'b0, 1'b1, 3, 1'b1);
    chk3("per stop", out4, done4, cnt4, '{o: 0, d: 0, c: 0});
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 3, 1'b0);
      chk($sformatf("per after stop k%0d done", k), int'(done4), 0);
    end

    // largest period for W=8
    step(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k <= 256; k++) begin
      step(k == 0, 1'b0, 255, 1'b0);
      chk3($sformatf("max k%0d", k), out1, done1, cnt1,
           oneshot(k, 0, 255));
    end

    retrig_run(7, 3);
    retrig_run(4, 3);
    retrig_run(4, 0);

    // async reset mid-count
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b0, 5, 1'b0);
    step(1'b0, 1'b0, 5, 1'b0);
    step(1'b0, 1'b0, 5, 1'b0);
    chk3("pre rst", out1, done1, cnt1, '{o: 1, d: 0, c: 2});
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk3("async rst count", out1, done1, cnt1, '{o: 0, d: 0, c: 0});
    chk3("async rst count d4", out4, done4, cnt4, '{o: 0, d: 0, c: 0});
    @(negedge clk);
    rst = 1'b0;

    // async reset while done is high
    step(1'b1, 1'b0, 0, 1'b0);
    chk("pre rst done", int'(done1), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst done", int'(done1), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k <= 3; k++) begin
      step(k == 0, 1'b0, 2, 1'b0);
      chk3($sformatf("post rst k%0d", k), out1, done1, cnt1,
           oneshot(k, 0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
